// File: rtl/cpu_ififo_pkg.sv
// Shared constants for the instruction FIFO: buffer geometry and the long-form opcode list.
package cpu_ififo_pkg;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
    localparam int CNT_W = 4;
    localparam int N_LONG = 17;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic [6:0] LONG_OPS [N_LONG] = '{
        7'h01, 7'h03, 7'h08, 7'h09, 7'h0c, 7'h0d, 7'h1a, 7'h1b, 7'h1d,
        7'h1f, 7'h20, 7'h22, 7'h24, 7'h36, 7'h37, 7'h38, 7'h39
    };

    // Long-form instructions carry a 32-bit operand in the two following halfwords.
    function automatic logic is_long(input logic [15:0] opcode);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_LONG; i++) begin
            if (opcode[14:8] == LONG_OPS[i]) hit = 1'b1;
        end
        return hit & ~opcode[15];
    endfunction

endpackage

// File: rtl/cpu_i_fifo_oplen.sv
// Instruction length decoder: returns the instruction length in halfwords (1 or 3).
module cpu_i_fifo_oplen
    import cpu_ififo_pkg::*;
(
    input  logic [15:0] opcode,
    output logic [1:0]  len
);

    assign len = is_long(opcode) ? 2'd3 : 2'd1;

endmodule

// File: rtl/cpu_i_fifo.sv
// Instruction FIFO: 32-bit fetch words in, halfword-granular instructions out, flushed by new-PC.
// Build option CPU_IFIFO_HALF_ALIGN_EN lets a flush to a halfword-aligned PC skip the first halfword.
module cpu_i_fifo
    import cpu_ififo_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] PC_i,
    input  logic        newPC_p_i,
    input  logic        write_en_i,
    input  logic        read_en_i,
    input  logic [31:0] data_i,
    output logic [15:0] opcode_o,
    output logic [31:0] operand_o,
    output logic        valid_o,
    output logic        empty_o,
    output logic        full_o,
    output logic [31:0] PC_o
);

    logic [15:0] mem [DEPTH];
    ptr_t        head;
    ptr_t        tail;
    cnt_t        count;
    logic [31:0] pc_q;
    logic [1:0]  len;
    logic        wr_acc;
    logic        rd_acc;
    cnt_t        wr_n;
    cnt_t        rd_n;
`ifdef CPU_IFIFO_HALF_ALIGN_EN
    logic        skip_q;
`endif

    cpu_i_fifo_oplen u_oplen (
        .opcode (opcode_o),
        .len    (len)
    );

    assign opcode_o  = mem[head];
    assign operand_o = {mem[head + 3'd1], mem[head + 3'd2]};
    assign valid_o   = (count >= {2'b00, len});
    assign empty_o   = (count == '0);
    assign full_o    = (count > 4'd6);
    assign PC_o      = pc_q;

    assign wr_acc = write_en_i & ~full_o;
    assign rd_acc = read_en_i & valid_o;
    assign rd_n   = rd_acc ? {2'b00, len} : '0;

    always_comb begin
        wr_n = '0;
        if (wr_acc) begin
`ifdef CPU_IFIFO_HALF_ALIGN_EN
            wr_n = skip_q ? 4'd1 : 4'd2;
`else
            wr_n = 4'd2;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            pc_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`ifdef CPU_IFIFO_HALF_ALIGN_EN
            skip_q <= 1'b0;
`endif
        end else if (newPC_p_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
`ifdef CPU_IFIFO_HALF_ALIGN_EN
            pc_q   <= PC_i;
            skip_q <= PC_i[1];
`else
            pc_q  <= PC_i & ~32'h3;
`endif
        end else begin
            if (wr_acc) begin
`ifdef CPU_IFIFO_HALF_ALIGN_EN
                if (skip_q) begin
                    mem[tail] <= data_i[15:0];
                end else begin
                    mem[tail]        <= data_i[31:16];
                    mem[tail + 3'd1] <= data_i[15:0];
                end
                skip_q <= 1'b0;
`else
                mem[tail]        <= data_i[31:16];
                mem[tail + 3'd1] <= data_i[15:0];
`endif
            end
            if (rd_acc) begin
                head <= head + {1'b0, len};
                pc_q <= pc_q + {29'd0, len, 1'b0};
            end
            tail  <= tail + wr_n[PTR_W-1:0];
            count <= count + wr_n - rd_n;
        end
    end

endmodule

// File: tb/tb_cpu_i_fifo.sv
// Self-checking bench for cpu_i_fifo (default build): directed plan items plus random traffic vs a queue model.
module tb_cpu_i_fifo;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] PC_i;
    logic        newPC_p_i;
    logic        write_en_i;
    logic        read_en_i;
    logic [31:0] data_i;
    logic [15:0] opcode_o;
    logic [31:0] operand_o;
    logic        valid_o;
    logic        empty_o;
    logic        full_o;
    logic [31:0] PC_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] mq [$];
    logic [31:0] mpc = 0;

    cpu_i_fifo dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .PC_i       (PC_i),
        .newPC_p_i  (newPC_p_i),
        .write_en_i (write_en_i),
        .read_en_i  (read_en_i),
        .data_i     (data_i),
        .opcode_o   (opcode_o),
        .operand_o  (operand_o),
        .valid_o    (valid_o),
        .empty_o    (empty_o),
        .full_o     (full_o),
        .PC_o       (PC_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int mlen(input logic [15:0] op);
        if (!op[15] && (op[14:8] inside {7'h01, 7'h03, 7'h08, 7'h09, 7'h0c, 7'h0d, 7'h1a,
                                          7'h1b, 7'h1d, 7'h1f, 7'h20, 7'h22, 7'h24,
                                          7'h36, 7'h37, 7'h38, 7'h39}))
            return 3;
        return 1;
    endfunction

    function automatic bit m_valid();
        return (mq.size() > 0) && (mq.size() >= mlen(mq[0]));
    endfunction

    task automatic model_step(input bit r, input bit f, input bit w, input bit rd,
                              input logic [31:0] pc, input logic [31:0] d);
        bit full_now, valid_now;
        int l;
        if (!r) begin
            mq.delete();
            mpc = 0;
        end else if (f) begin
            mq.delete();
            mpc = pc & ~32'h3;
        end else begin
            full_now  = mq.size() > 6;
            valid_now = m_valid();
            if (rd && valid_now) begin
                l = mlen(mq[0]);
                for (int k = 0; k < l; k++) void'(mq.pop_front());
                mpc = mpc + 32'(2 * l);
            end
            if (w && !full_now) begin
                mq.push_back(d[31:16]);
                mq.push_back(d[15:0]);
            end
        end
    endtask

    task automatic check_all();
        chk_eq("empty", 32'(empty_o), 32'(mq.size() == 0));
        chk_eq("full", 32'(full_o), 32'(mq.size() > 6));
        chk_eq("valid", 32'(valid_o), 32'(m_valid()));
        chk_eq("pc", PC_o, mpc);
        if (mq.size() > 0) chk_eq("opcode", 32'(opcode_o), 32'(mq[0]));
        if (m_valid() && mlen(mq[0]) == 3) chk_eq("operand", operand_o, {mq[1], mq[2]});
    endtask

    task automatic cyc(input bit r, input bit f, input bit w, input bit rd,
                       input logic [31:0] pc, input logic [31:0] d);
        rst_i = r; newPC_p_i = f; write_en_i = w; read_en_i = rd; PC_i = pc; data_i = d;
        model_step(r, f, w, rd, pc, d);
        @(posedge clk_i);
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] d;
        bit r, f, w, rd;
        rst_i = 1'b0; newPC_p_i = 0; write_en_i = 0; read_en_i = 0; PC_i = 0; data_i = 0;

        // reset, with a concurrent flush/write/read that must be overridden
        cyc(0, 1, 1, 1, 32'h5555_0000, 32'h0100_1234);
        chk_eq("rst_empty", 32'(empty_o), 32'd1);
        chk_eq("rst_valid", 32'(valid_o), 32'd0);
        chk_eq("rst_full", 32'(full_o), 32'd0);
        chk_eq("rst_pc", PC_o, 32'd0);
        chk_eq("rst_opcode", 32'(opcode_o), 32'd0);
        chk_eq("rst_operand", operand_o, 32'd0);

        // short instructions
        cyc(1, 1, 0, 0, 32'h1000, 0);
        cyc(1, 0, 1, 0, 0, 32'h2F12_3456);
        chk_eq("short_op", 32'(opcode_o), 32'h2F12);
        chk_eq("short_valid", 32'(valid_o), 32'd1);
        chk_eq("short_pc", PC_o, 32'h1000);
        cyc(1, 0, 0, 1, 0, 0);
        chk_eq("short_op2", 32'(opcode_o), 32'h3456);
        chk_eq("short_pc2", PC_o, 32'h1002);
        cyc(1, 0, 0, 1, 0, 0);

        // long instruction assembled over two writes
        cyc(1, 0, 1, 0, 0, 32'h0100_DEAD);
        chk_eq("long_valid0", 32'(valid_o), 32'd0);
        cyc(1, 0, 1, 0, 0, 32'hBEEF_0000);
        chk_eq("long_valid1", 32'(valid_o), 32'd1);
        chk_eq("long_operand", operand_o, 32'hDEAD_BEEF);
        cyc(1, 0, 0, 1, 0, 0);
        chk_eq("long_pc", PC_o, 32'h1004 + 32'd6);
        chk_eq("long_next", 32'(opcode_o), 32'h0000);

        // fill and drain around the full threshold
        cyc(1, 1, 0, 0, 32'h2000, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 0, 32'h4000_4000 + 32'(i));
        chk_eq("fill_full", 32'(full_o), 32'd1);
        cyc(1, 0, 1, 0, 0, 32'h7777_7777);
        cyc(1, 0, 0, 1, 0, 0);
        chk_eq("full_at7", 32'(full_o), 32'd1);
        cyc(1, 0, 0, 1, 0, 0);
        chk_eq("full_at6", 32'(full_o), 32'd0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1, 0, 0);
        chk_eq("drain_empty", 32'(empty_o), 32'd1);

        // flush with concurrent write while holding 6 halfwords
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 32'h4100_4100);
        cyc(1, 1, 1, 1, 32'h3003, 32'h1111_2222);
        chk_eq("flush_empty", 32'(empty_o), 32'd1);
        chk_eq("flush_pc", PC_o, 32'h3000);
        cyc(1, 0, 0, 0, 0, 0);
        chk_eq("flush_discard", 32'(empty_o), 32'd1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 199) != 0);
            f  = ($urandom_range(0, 31) == 0);
            w  = ($urandom_range(0, 99) < 55);
            rd = ($urandom_range(0, 99) < 50);
            d  = $urandom;
            if ($urandom_range(0, 2) == 0)
                d[31:16] = {1'b0, 7'($urandom_range(0, 63)), 8'($urandom)};
            cyc(r, f, w, rd, $urandom, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
